// File: rtl/pattern_pkg.sv
// Shared code, pattern and FSM-state constants for the pattern transmitter.
package pattern_pkg;

  localparam logic [1:0] CODE_SPACER = 2'd0;
  localparam logic [1:0] CODE_P001   = 2'd1;
  localparam logic [1:0] CODE_P110   = 2'd2;
  localparam logic [1:0] CODE_RSVD   = 2'd3;

  localparam logic [2:0] PAT_SPACER = 3'b000;
  localparam logic [2:0] PAT_001    = 3'b001;
  localparam logic [2:0] PAT_110    = 3'b110;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  function automatic logic [2:0] code_to_pattern(input logic [1:0] code);
    case (code)
      CODE_P110: code_to_pattern = PAT_110;
      CODE_P001: code_to_pattern = PAT_001;
      default:   code_to_pattern = PAT_SPACER;
    endcase
  endfunction

endpackage

// File: rtl/pattern_fifo.sv
// Code FIFO for pattern_tx: DEPTH entries (power of 2), push ignored when full,
// pop ignored when empty, pointers wrap modulo DEPTH.
module pattern_fifo
  import pattern_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [1:0]             push_code,
  input  logic                   pop,
  output logic [1:0]             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is data only; occupancy is tracked by the reset pointers/count.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_code;
  end

endmodule

// File: rtl/pattern_tx.sv
// Serial 3-bit pattern transmitter fed by a code FIFO, MSB first.
// Optional PATTERN_TX_GUARD_EN adds one inverted guard bit after each pattern.
module pattern_tx
  import pattern_pkg::*;
#(
  parameter int   FIFO_DEPTH = 4,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_valid,
  input  logic [1:0] req_code,
  output logic       req_ready,
  output logic       o,
  output logic       busy,
  output logic       done,
  output logic       err
);

  logic [1:0]                 state;
  logic [1:0]                 idx;
  logic                       ready_en;
  logic                       accept;
  logic                       push;
  logic                       load;
  logic [1:0]                 head;
  logic [2:0]                 head_pat;
  logic                       full;
  logic                       empty;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic [1:0]                 sreg_p0;
  logic                       o_p0;
  logic                       done_p0;
  logic                       err_p0;

  assign req_ready = ready_en && !full;
  assign accept    = req_valid && req_ready;
  assign push      = accept && (req_code != CODE_RSVD);
  assign head_pat  = code_to_pattern(head);
  assign busy      = (state != ST_IDLE) || (count != '0);
  assign o         = o_p0;
  assign done      = done_p0;
  assign err       = err_p0;

  pattern_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .push_code(req_code),
    .pop      (load),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // Head is popped on the same edge its bit2 goes out, so patterns run back-to-back.
  always_comb begin
    load = 1'b0;
    if (!empty) begin
      case (state)
        ST_IDLE:  load = 1'b1;
`ifdef PATTERN_TX_GUARD_EN
        ST_GUARD: load = 1'b1;
`else
        ST_SHIFT: load = (idx == 2'd0);
`endif
        default:  load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      idx      <= 2'd0;
      o_p0     <= IDLE_BIT;
      done_p0  <= 1'b0;
      err_p0   <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      err_p0   <= accept && (req_code == CODE_RSVD);
      done_p0  <= 1'b0;
      if (load) begin
        state <= ST_SHIFT;
        idx   <= 2'd2;
        o_p0  <= head_pat[2];
      end else begin
        case (state)
          ST_SHIFT: begin
            if (idx == 2'd2) begin
              idx  <= 2'd1;
              o_p0 <= sreg_p0[1];
            end else if (idx == 2'd1) begin
              idx     <= 2'd0;
              o_p0    <= sreg_p0[0];
              done_p0 <= 1'b1;
            end else begin
`ifdef PATTERN_TX_GUARD_EN
              state <= ST_GUARD;
              o_p0  <= ~sreg_p0[0];
`else
              state <= ST_IDLE;
              o_p0  <= IDLE_BIT;
`endif
            end
          end
          default: begin
            state <= ST_IDLE;
            o_p0  <= IDLE_BIT;
          end
        endcase
      end
    end
  end

  // Bit2 leaves directly from the FIFO head; only bits 1..0 need holding.
  always_ff @(posedge clock) begin
    if (load) sreg_p0 <= head_pat[1:0];
  end

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx with a pattern scoreboard keyed on done.
module tb_pattern_tx;

  localparam logic IDLE_BIT = 1'b1;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic [1:0] req_code;
  logic       req_ready;
  logic       o;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_q [$];
  logic       o_log [$];
  logic       d_log [$];
  logic       b_log [$];
  logic       rec_en = 1'b0;
  logic [2:0] hist = 3'b000;

  always #5 clock = ~clock;

  pattern_tx #(
    .FIFO_DEPTH(4),
    .IDLE_BIT  (IDLE_BIT)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_code (req_code),
    .req_ready(req_ready),
    .o        (o),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] tb_pat(input logic [1:0] c);
    case (c)
      2'd2:    tb_pat = 3'b110;
      2'd1:    tb_pat = 3'b001;
      default: tb_pat = 3'b000;
    endcase
  endfunction

  task automatic cyc();
    @(negedge clock);
    if (rec_en) begin
      o_log.push_back(o);
      d_log.push_back(done);
      b_log.push_back(busy);
    end
  endtask

  task automatic drive(input logic [1:0] c);
    req_valid = 1'b1;
    req_code  = c;
    if (req_ready && c != 2'd3) exp_q.push_back(tb_pat(c));
  endtask

  task automatic clear_logs();
    o_log.delete();
    d_log.delete();
    b_log.delete();
  endtask

  // Scoreboard: the two bits before done plus the done bit form one pattern.
  always @(negedge clock) begin
    if (!reset_n) begin
      hist = 3'b000;
    end else begin
      hist = {hist[1:0], o};
      if (done) begin
        check("sb_underflow", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("sb_pattern", int'(hist), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:13] eo;
    logic [0:13] ed;
    logic [0:13] eb;
    int          accepts;
    int          first_full;
    logic [1:0]  c;

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_code  = 2'd0;
    repeat (2) @(negedge clock);
    check("rst_o", int'(o), int'(IDLE_BIT));
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(req_ready), 0);
    reset_n = 1'b1;
    cyc();
    check("ready_after_release", int'(req_ready), 1);
    check("idle_o", int'(o), int'(IDLE_BIT));

    // Single 110 pattern: latency and done placement.
    drive(2'd2);
    cyc();
    req_valid = 1'b0;
    check("a_busy_queued", int'(busy), 1);
    check("a_o_pre", int'(o), int'(IDLE_BIT));
    cyc();
    check("a_bit2", int'(o), 1);
    cyc();
    check("a_bit1", int'(o), 1);
    check("a_done_bit1", int'(done), 0);
    cyc();
    check("a_bit0", int'(o), 0);
    check("a_done_bit0", int'(done), 1);
    cyc();
`ifdef PATTERN_TX_GUARD_EN
    check("a_guard_o", int'(o), 1);
    check("a_guard_busy", int'(busy), 1);
    check("a_guard_done", int'(done), 0);
    cyc();
`endif
    check("a_o_after", int'(o), int'(IDLE_BIT));
    check("a_done_after", int'(done), 0);
    check("a_busy_after", int'(busy), 0);

    // Reserved code: consumed, err next cycle, nothing queued.
    drive(2'd3);
    cyc();
    req_valid = 1'b0;
    check("c_err_pulse", int'(err), 1);
    check("c_busy", int'(busy), 0);
    check("c_o", int'(o), int'(IDLE_BIT));
    cyc();
    check("c_err_clear", int'(err), 0);
    check("c_o_still_idle", int'(o), int'(IDLE_BIT));

    // Back-to-back codes 1,2,0.
    clear_logs();
    rec_en = 1'b1;
    drive(2'd1);
    cyc();
    drive(2'd2);
    cyc();
    drive(2'd0);
    cyc();
    req_valid = 1'b0;
    repeat (11) cyc();
    rec_en = 1'b0;
`ifdef PATTERN_TX_GUARD_EN
    eo = 14'b10010110100011;
    ed = 14'b00010001000100;
    eb = 14'b11111111111110;
`else
    eo = 14'b10011100001111;
    ed = 14'b00010010010000;
    eb = 14'b11111111110000;
`endif
    check("b_log_len", o_log.size(), 14);
    for (int i = 0; i < 14 && i < o_log.size(); i++) begin
      check($sformatf("b_o[%0d]", i), int'(o_log[i]), int'(eo[i]));
      check($sformatf("b_done[%0d]", i), int'(d_log[i]), int'(ed[i]));
      check($sformatf("b_busy[%0d]", i), int'(b_log[i]), int'(eb[i]));
    end

    // Hold req_valid until the FIFO fills while it drains one pattern at a time.
    accepts    = 0;
    first_full = -1;
    for (int i = 0; i < 12; i++) begin
      c = 2'(i % 3);
      if (!req_ready && first_full < 0) first_full = accepts;
      if (req_ready) accepts++;
      drive(c);
      cyc();
    end
    req_valid = 1'b0;
`ifdef PATTERN_TX_GUARD_EN
    check("d_accepts_at_full", first_full, 5);
`else
    check("d_accepts_at_full", first_full, 6);
`endif
    for (int n = 0; n < 80 && busy; n++) cyc();
    check("d_drained", int'(busy), 0);
    check("d_queue_empty", exp_q.size(), 0);

    // Reset during bit1 of a 110 with another code queued behind it.
    drive(2'd2);
    cyc();
    drive(2'd1);
    cyc();
    req_valid = 1'b0;
    cyc();
    check("e_bit1_before_reset", int'(o), 1);
    reset_n = 1'b0;
    #1;
    check("e_rst_o", int'(o), int'(IDLE_BIT));
    check("e_rst_busy", int'(busy), 0);
    check("e_rst_done", int'(done), 0);
    check("e_rst_err", int'(err), 0);
    check("e_rst_ready", int'(req_ready), 0);
    exp_q.delete();
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    check("e_ready_release", int'(req_ready), 1);
    check("e_fifo_empty", int'(busy), 0);
    check("e_o_idle", int'(o), int'(IDLE_BIT));
    clear_logs();
    rec_en = 1'b1;
    drive(2'd1);
    cyc();
    req_valid = 1'b0;
    repeat (4) cyc();
    rec_en = 1'b0;
    check("e_log_len", o_log.size(), 5);
    if (o_log.size() == 5) begin
      check("e_o0", int'(o_log[0]), int'(IDLE_BIT));
      check("e_o1", int'(o_log[1]), 0);
      check("e_o2", int'(o_log[2]), 0);
      check("e_o3", int'(o_log[3]), 1);
      check("e_done3", int'(d_log[3]), 1);
    end
    for (int n = 0; n < 20 && busy; n++) cyc();
    check("e_drained", int'(busy), 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, code FIFO entries (power of 2, 2..16).
REQ-002 Parameter IDLE_BIT, default 1'b0, level driven on o when no pattern is in flight.
REQ-003 clock  input  1  single clock; all state updates on posedge only.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  code request valid.
REQ-006 req_code  input  2  code to transmit: 2 = pattern 110, 1 = pattern 001, 0 = spacer 000, 3 = reserved.
REQ-007 req_ready  output  1  FIFO can accept a code this cycle.
REQ-008 o  output  1  registered serial bit stream, MSB of each pattern first.
REQ-009 busy  output  1  a pattern or guard bit is on o, or the FIFO is non-empty.
REQ-010 done  output  1  one-cycle pulse, concurrent with the last bit of each pattern.
REQ-011 err  output  1  one-cycle pulse, the cycle after a reserved code is offered with req_ready high.

Function
REQ-012 A push occurs at an edge where req_valid && req_ready; req_ready SHALL equal !full, with no bypass when full, even on a simultaneous pop.
REQ-013 Reserved code 3 SHALL be consumed (handshake completes) but not queued; err pulses the next cycle.
REQ-014 FSM states SHALL be IDLE, SHIFT and GUARD (GUARD exists only per REQ-024).
REQ-015 IDLE -> SHIFT: at an edge with FIFO non-empty, pop the head, load a 3-bit shift register, drive bit2 on o, and set bit index to 2.
REQ-016 SHIFT: each edge advances one bit (bit1, then bit0); done is high while bit0 is driven.
REQ-017 At the edge ending bit0: if the FIFO is non-empty, load the next pattern with no gap (back-to-back); otherwise go to IDLE and drive IDLE_BIT.
REQ-018 Latency: a push at edge k into an empty, idle block puts bit2 on o after edge k+1, bit1 after k+2 and bit0 after k+3.
REQ-019 A simultaneous push and pop SHALL keep the count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-020 A code SHALL NOT be lost or duplicated; transmission order equals acceptance order.
REQ-021 busy SHALL deassert in the first cycle in IDLE with the FIFO empty.

Reset
REQ-022 While reset_n is low, the following SHALL hold immediately, regardless of any in-flight pattern:
- o = IDLE_BIT, done = 0, err = 0, busy = 0;
- req_ready = 0, then 1 from the first edge after release;
- FIFO emptied, FSM = IDLE.
REQ-023 A partially transmitted pattern SHALL be abandoned at reset and not resumed.

Configuration
REQ-024 Macro PATTERN_TX_GUARD_EN defined: after each pattern's bit0, the FSM SHALL enter GUARD for one cycle, driving the inverse of bit0, before the next pattern or IDLE; done stays on bit0.
REQ-025 Macro undefined: the GUARD state and its logic are absent; behaviour per REQ-017.

Structure
REQ-026 Shared package pattern_pkg SHALL hold the code constants (CODE_SPACER=0, CODE_P001=1, CODE_P110=2, CODE_RSVD=3), the 3-bit pattern constants and the FSM state encoding.
REQ-027 The FIFO SHALL be a sub-module pattern_fifo (parameter DEPTH; push/pop/full/empty/count); the FSM and shift register stay in pattern_tx.

Verification
REQ-028 Reset, then push code 2 at edge 1 -> o = 1,1,0 after edges 2,3,4; done high in the third bit cycle; o = IDLE_BIT after edge 5.
REQ-029 Push codes 1,2,0 on consecutive edges -> o = 0,0,1,1,1,0,0,0,0 with no gap; done pulses 3 times; busy drops after the last bit.
REQ-030 Hold req_valid with FIFO_DEPTH=4 and no drain -> req_ready low after 4 accepts (the first entry may pop); no push while full; all accepted codes later emitted in order.
REQ-031 Offer code 3 -> err pulse the next cycle, nothing emitted, FIFO count unchanged.
REQ-032 Assert reset_n low while bit1 of a 110 pattern is on o -> o = IDLE_BIT immediately; FIFO empty; the next push after release transmits cleanly.
REQ-033 With PATTERN_TX_GUARD_EN, push codes 2,1 -> o = 1,1,0,1,0,0,1,0.
